adc_stream_sched: RTL and testbench

//  Capture scheduler for the dual-ADC sync FIFO bank. Takes the 48-bit frame
//  {B1,B0,A1,A0} and its sample strobe in the system clock domain. Captures a

---
 rtl/adc_stream_sched.sv | 141 ++++++++++++++
 tb/tb_adc_stream_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_stream_sched.sv
// Dual-ADC capture scheduler: latches frames on strobe, serialises enabled
// lanes into a tagged 16-bit valid/ready stream, and counts dropped frames.
//
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   start_i, abort_i        capture control
//   ch_en_i, frame_len_i    channel enables and frame count, latched at start
//   smp_valid_i, data_adc_i frame strobe and {B1,B0,A1,A0} lanes
//   out_data_o/valid/ready  tagged sample stream {lane,2'b00,sample}
//   out_last_o              final word of the final frame
//   busy_o, done_o          status; done pulses after the final accept
//   overrun_o, drop_cnt_o   sticky drop flag and saturating drop count
module adc_stream_sched #(
  parameter int SAMPLE_W = 12,
  parameter int CNT_W    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [1:0]            ch_en_i,
  input  logic [CNT_W-1:0]      frame_len_i,
  input  logic                  smp_valid_i,
  input  logic [4*SAMPLE_W-1:0] data_adc_i,
  output logic [15:0]           out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overrun_o,
  output logic [CNT_W-1:0]      drop_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t                state_q;
  logic [1:0]            en_q;
  logic [1:0]            lane_q;
  logic [CNT_W-1:0]      rem_q;
  logic [CNT_W-1:0]      drop_q;
  logic [4*SAMPLE_W-1:0] frame_q;
  logic                  ovr_q;
  logic                  done_q;

  logic [1:0]    first_lane;
  logic [1:0]    last_lane;
  logic          is_last;
  logic          accept;
  logic          rem_one;
  logic          start_ok;
  logic [SAMPLE_W-1:0] sample;

  // Channel A owns lanes 0/1, channel B lanes 2/3.
  assign first_lane = en_q[0] ? 2'd0 : 2'd2;
  assign last_lane  = en_q[1] ? 2'd3 : 2'd1;
  assign is_last    = (lane_q == last_lane);
  assign accept     = (state_q == EMIT) && out_ready_i;
  assign rem_one    = (rem_q == CNT_W'(1));
  assign start_ok   = start_i && (frame_len_i != '0)
                      && (ch_en_i != 2'b00);

  assign sample = frame_q[lane_q*SAMPLE_W +: SAMPLE_W];

  assign out_data_o  = {lane_q, {(14-SAMPLE_W){1'b0}}, sample};
  assign out_valid_o = (state_q == EMIT);
  assign out_last_o  = out_valid_o && is_last && rem_one;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign overrun_o   = ovr_q;
  assign drop_cnt_o  = drop_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      en_q    <= '0;
      lane_q  <= '0;
      rem_q   <= '0;
      drop_q  <= '0;
      frame_q <= '0;
      ovr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i && state_q != IDLE) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start_ok) begin
              state_q <= WAIT;
              en_q    <= ch_en_i;
              rem_q   <= frame_len_i;
              ovr_q   <= 1'b0;
              drop_q  <= '0;
            end
          end
          WAIT: begin
            if (smp_valid_i) begin
              frame_q <= data_adc_i;
              lane_q  <= first_lane;
              state_q <= EMIT;
            end
          end
          EMIT: begin
            if (accept) begin
              if (is_last) begin
                rem_q <= rem_q - CNT_W'(1);
                if (rem_one) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
                end else if (smp_valid_i) begin
                  frame_q <= data_adc_i;
                  lane_q  <= first_lane;
                end else begin
                  state_q <= WAIT;
                end
              end else begin
                lane_q <= lane_q + 2'd1;
              end
            end
            // Only a strobe landing exactly on the hand-off
            // to a remaining frame is kept.
            if (smp_valid_i &&
                !(accept && is_last && !rem_one)) begin
              ovr_q <= 1'b1;
              if (drop_q != '1)
                drop_q <= drop_q + CNT_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_stream_sched.sv
// Bench for adc_stream_sched: vector table, corner sequences, and random
// stimulus against a queue-based reference model.
module tb_adc_stream_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, smp, ready;
  logic [1:0]  en;
  logic [15:0] len;
  logic [47:0] data;
  logic [15:0] out_data;
  logic        out_valid, out_last, busy, done, ovr;
  logic [15:0] drop_cnt;

  adc_stream_sched dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .ch_en_i(en), .frame_len_i(len), .smp_valid_i(smp),
    .data_adc_i(data), .out_data_o(out_data),
    .out_valid_o(out_valid), .out_ready_i(ready),
    .out_last_o(out_last), .busy_o(busy), .done_o(done),
    .overrun_o(ovr), .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a word queue per captured frame.
  bit          m_busy;
  int          m_left;
  logic [1:0]  m_en;
  logic [15:0] m_q[$];
  bit          m_done, m_ovr;
  int          m_drops;

  typedef struct {
    bit          start;
    logic [1:0]  en;
    logic [15:0] len;
    bit          smp;
    logic [47:0] data;
    bit          ready;
    bit          v;
    logic [15:0] d;
    bit          l;
    bit          b;
    bit          dn;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_left = 0; m_en = 0; m_q.delete();
    m_done = 0; m_ovr = 0; m_drops = 0;
  endtask

  task automatic push_frame();
    for (int l = 0; l < 4; l++) begin
      logic [1:0] tag;
      tag = l[1:0];
      if (m_en[l/2]) m_q.push_back({tag, 2'b00, data[l*12 +: 12]});
    end
  endtask

  task automatic model_step();
    bit nd, acc_last, cont;
    nd = 0; cont = 0;
    if (m_busy && abort) begin
      m_busy = 0;
      m_q.delete();
    end else if (!m_busy) begin
      if (start && len != 0 && en != 0) begin
        m_busy = 1; m_left = len; m_en = en;
        m_ovr = 0; m_drops = 0;
      end
    end else if (m_q.size() == 0) begin
      if (smp) push_frame();
    end else begin
      acc_last = ready && m_q.size() == 1;
      if (ready) void'(m_q.pop_front());
      if (acc_last) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; nd = 1;
        end else cont = 1;
      end
      if (smp) begin
        if (cont) push_frame();
        else begin
          m_ovr = 1;
          if (m_drops < 65535) m_drops++;
        end
      end
    end
    m_done = nd;
  endtask

  task automatic compare_model();
    bit v;
    v = m_q.size() != 0;
    chk("valid", 32'(out_valid), 32'(v));
    if (v) chk("data", 32'(out_data), 32'(m_q[0]));
    chk("last", 32'(out_last),
        32'(v && m_q.size() == 1 && m_left == 1));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("overrun", 32'(ovr), 32'(m_ovr));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic idle_in();
    start = 0; abort = 0; smp = 0;
  endtask

  initial begin
    int nwords;
    bit seen_done;
    logic [15:0] held;

    rst = 1; start = 0; abort = 0; smp = 0; ready = 0;
    en = 0; len = 0; data = 0;
    model_reset();
    #2;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    #10 rst = 0;

    // Vector table: single 4-lane frame, then ignored starts.
    tbl[0] = '{1,2'b11,16'd1,0,48'h0,0, 0,16'h0,0,1,0};
    tbl[1] = '{0,2'b11,16'd1,1,48'h444333222111,0,
               1,16'h0111,0,1,0};
    tbl[2] = '{0,2'b11,16'd1,0,48'h0,1, 1,16'h4222,0,1,0};
    tbl[3] = '{0,2'b11,16'd1,0,48'h0,1, 1,16'h8333,0,1,0};
    tbl[4] = '{0,2'b11,16'd1,0,48'h0,1, 1,16'hC444,1,1,0};
    tbl[5] = '{0,2'b11,16'd1,0,48'h0,1, 0,16'h0,0,0,1};
    tbl[6] = '{1,2'b11,16'd0,0,48'h0,1, 0,16'h0,0,0,0};
    tbl[7] = '{1,2'b00,16'd5,0,48'h0,1, 0,16'h0,0,0,0};
    tbl[8] = '{0,2'b11,16'd1,1,48'h123456789ABC,1,
               0,16'h0,0,0,0};
    for (int i = 0; i < 9; i++) begin
      start = tbl[i].start; en = tbl[i].en; len = tbl[i].len;
      smp = tbl[i].smp; data = tbl[i].data; ready = tbl[i].ready;
      tick();
      chk("tbl_valid", 32'(out_valid), 32'(tbl[i].v));
      if (tbl[i].v) chk("tbl_data", 32'(out_data), 32'(tbl[i].d));
      chk("tbl_last", 32'(out_last), 32'(tbl[i].l));
      chk("tbl_busy", 32'(busy), 32'(tbl[i].b));
      chk("tbl_done", 32'(done), 32'(tbl[i].dn));
    end
    idle_in();

    // Channel B only, 3 frames, strobe every 4 cycles.
    ready = 1; en = 2'b10; len = 3; start = 1;
    tick();
    start = 0;
    nwords = 0; seen_done = 0;
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < 4; c++) begin
        smp = (c == 0);
        data = {16'($urandom), $urandom};
        if (out_valid && ready) begin
          nwords++;
          chk("b_tag", 32'(out_data[15]), 1);
        end
        tick();
        seen_done |= done;
      end
    end
    smp = 0;
    chk("b_words", 32'(nwords), 6);
    chk("b_done", 32'(seen_done), 1);
    chk("b_ovr", 32'(ovr), 0);

    // Back-pressure with a dropped frame.
    ready = 0; en = 2'b11; len = 2; start = 1;
    tick();
    start = 0; smp = 1; data = 48'hBBBAAA999888;
    tick();
    held = out_data;
    for (int i = 0; i < 10; i++) begin
      smp = (i == 4);
      tick();
      chk("bp_hold", 32'(out_data), 32'(held));
    end
    smp = 0;
    chk("bp_ovr", 32'(ovr), 1);
    chk("bp_drop", 32'(drop_cnt), 1);
    ready = 1;
    repeat (5) tick();
    smp = 1; data = 48'h777666555444;
    tick();
    smp = 0;
    repeat (5) tick();
    chk("bp_idle", 32'(busy), 0);

    // Back-to-back strobe on the last-word accept.
    en = 2'b01; len = 2; start = 1;
    tick();
    start = 0; smp = 1; data = 48'h000000222111;
    tick();
    smp = 0;
    tick();
    smp = 1; data = 48'h000000444333;
    tick();
    smp = 0;
    chk("b2b_valid", 32'(out_valid), 1);
    chk("b2b_data", 32'(out_data), 32'h0333);
    chk("b2b_drop", 32'(drop_cnt), 0);
    repeat (3) tick();

    // Abort mid-handshake, then a clean capture.
    ready = 0; en = 2'b11; len = 2; start = 1;
    tick();
    start = 0; smp = 1;
    tick();
    tick();
    smp = 0; abort = 1;
    tick();
    abort = 0;
    chk("ab_valid", 32'(out_valid), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_ovr_kept", 32'(ovr), 1);
    tick();
    chk("ab_nodone", 32'(done), 0);
    ready = 1; len = 1; start = 1;
    tick();
    start = 0;
    chk("ab_ovr_clr", 32'(ovr), 0);
    chk("ab_drop_clr", 32'(drop_cnt), 0);
    smp = 1; data = {16'($urandom), $urandom};
    tick();
    smp = 0;
    repeat (5) tick();

    // Async reset mid-EMIT.
    ready = 0; len = 2; start = 1;
    tick();
    start = 0; smp = 1;
    tick();
    tick();
    smp = 0;
    #3 rst = 1;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_data", 32'(out_data), 0);
    chk("arst_last", 32'(out_last), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ovr", 32'(ovr), 0);
    chk("arst_drop", 32'(drop_cnt), 0);
    model_reset();
    #1 rst = 0;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 9) == 0);
      en    = 2'($urandom);
      len   = 16'($urandom_range(0, 4));
      smp   = ($urandom_range(0, 3) == 0);
      ready = ($urandom_range(0, 9) < 7);
      abort = m_busy && ($urandom_range(0, 49) == 0);
      data  = {16'($urandom), $urandom};
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
